fa_response_checker: RTL and testbench

//  Clocked self-checking monitor on the observation side of the full-adder lab DUT.

---
 rtl/fa_response_checker_if.sv | 32 +++
 rtl/fa_response_checker.sv | 136 +++++++++++++
 tb/tb_fa_response_checker.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fa_response_checker_if.sv
// Observation-side bundle for the full-adder response checker: strobed sample in,
// verdict and statistics out.
interface fa_response_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic             vec_valid;
    logic             a;
    logic             b;
    logic             c;
    logic             y1;
    logic             y2;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] vec_cnt;
    logic [7:0]       cov_map;
    logic [4:0]       first_fail;
    logic             mismatch;

    modport master (
        output start, stop, vec_valid, a, b, c, y1, y2,
        input  busy, done, pass, fail_cnt, vec_cnt, cov_map, first_fail, mismatch
    );

    modport slave (
        input  start, stop, vec_valid, a, b, c, y1, y2,
        output busy, done, pass, fail_cnt, vec_cnt, cov_map, first_fail, mismatch
    );
endinterface

// File: rtl/fa_response_checker.sv
// Clocked full-adder response checker: two-stage compare pipeline feeding saturating
// pass/fail statistics, input coverage map and first-failure capture.
module fa_response_checker #(
    parameter int CNT_W       = 8,
    parameter int MIN_VECTORS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fa_response_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic             stop_pend_q, stop_pend_d;
    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_abc_q, s1_abc_d;
    logic [1:0]       s1_obs_q, s1_obs_d;
    logic             s1_mis_q, s1_mis_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [7:0]       cov_map_q, cov_map_d;
    logic [4:0]       first_fail_q, first_fail_d;
    logic             mismatch_q, mismatch_d;

    logic exp_sum;
    logic exp_carry;
    logic complete;
    logic end_req;
    logic accept;

    always_comb begin
        exp_sum   = bus.a ^ bus.b ^ bus.c;
        exp_carry = (bus.a & bus.b) | (bus.b & bus.c) | (bus.a & bus.c);
        complete  = (cov_map_q == 8'hFF) && (32'(vec_cnt_q) >= 32'(MIN_VECTORS));
        end_req   = bus.stop || stop_pend_q || complete;

        state_d      = state_q;
        stop_pend_d  = stop_pend_q;
        s1_valid_d   = 1'b0;
        s1_abc_d     = s1_abc_q;
        s1_obs_d     = s1_obs_q;
        s1_mis_d     = s1_mis_q;
        vec_cnt_d    = vec_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        cov_map_d    = cov_map_q;
        first_fail_d = first_fail_q;
        mismatch_d   = 1'b0;
        accept       = 1'b0;

        if (s1_valid_q) begin
            vec_cnt_d           = (vec_cnt_q == '1) ? vec_cnt_q : vec_cnt_q + 1'b1;
            cov_map_d[s1_abc_q] = 1'b1;
            if (s1_mis_q) begin
                mismatch_d = 1'b1;
                if (fail_cnt_q == '0) begin
                    first_fail_d = {s1_abc_q, s1_obs_q};
                end
                fail_cnt_d = (fail_cnt_q == '1) ? fail_cnt_q : fail_cnt_q + 1'b1;
            end
        end

        // Leaving RUN waits for stage 1 to drain so an in-flight vector is still counted.
        case (state_q)
            IDLE: ;
            RUN: begin
                if (end_req) begin
                    if (s1_valid_q) begin
                        stop_pend_d = 1'b1;
                    end else begin
                        state_d     = DONE;
                        stop_pend_d = 1'b0;
                    end
                end else begin
                    accept = bus.vec_valid;
                end
            end
            DONE: ;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_abc_d   = {bus.a, bus.b, bus.c};
            s1_obs_d   = {bus.y1, bus.y2};
            s1_mis_d   = ({bus.y1, bus.y2} != {exp_carry, exp_sum});
        end

        if (bus.start) begin
            state_d      = RUN;
            stop_pend_d  = 1'b0;
            s1_valid_d   = 1'b0;
            vec_cnt_d    = '0;
            fail_cnt_d   = '0;
            cov_map_d    = '0;
            first_fail_d = '0;
            mismatch_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            stop_pend_q  <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_abc_q     <= '0;
            s1_obs_q     <= '0;
            s1_mis_q     <= 1'b0;
            vec_cnt_q    <= '0;
            fail_cnt_q   <= '0;
            cov_map_q    <= '0;
            first_fail_q <= '0;
            mismatch_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            stop_pend_q  <= stop_pend_d;
            s1_valid_q   <= s1_valid_d;
            s1_abc_q     <= s1_abc_d;
            s1_obs_q     <= s1_obs_d;
            s1_mis_q     <= s1_mis_d;
            vec_cnt_q    <= vec_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            cov_map_q    <= cov_map_d;
            first_fail_q <= first_fail_d;
            mismatch_q   <= mismatch_d;
        end
    end

    assign bus.busy       = (state_q == RUN);
    assign bus.done       = (state_q == DONE);
    assign bus.pass       = (state_q == DONE) && (fail_cnt_q == '0) && (cov_map_q == 8'hFF);
    assign bus.vec_cnt    = vec_cnt_q;
    assign bus.fail_cnt   = fail_cnt_q;
    assign bus.cov_map    = cov_map_q;
    assign bus.first_fail = first_fail_q;
    assign bus.mismatch   = mismatch_q;
endmodule

// File: tb/tb_fa_response_checker.sv
// Table-driven bench for fa_response_checker with a scoreboard of per-vector
// mismatch/counter expectations, plus a CNT_W=2 instance for saturation.
module tb_fa_response_checker;
    typedef struct {
        logic a, b, c, y1, y2;
        logic mis;
    } vec_t;

    typedef struct {
        int         due;
        logic       mis;
        logic [7:0] vcnt;
        logic [7:0] fcnt;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    vec_t tbl[11];
    sb_t  sb[$];
    logic [7:0] m_vcnt, m_fcnt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fa_response_checker_if #(.CNT_W(8)) bus ();
    fa_response_checker_if #(.CNT_W(2)) bus2 ();

    fa_response_checker #(.CNT_W(8), .MIN_VECTORS(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    fa_response_checker #(.CNT_W(2), .MIN_VECTORS(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(logic [4:0] abcyy, logic mis);
        vec_t v;
        {v.a, v.b, v.c, v.y1, v.y2} = abcyy;
        v.mis = mis;
        return v;
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            sb_t e;
            e = sb.pop_front();
            if (e.due < cyc) check("sb_stale", 32'(e.due), 32'(cyc));
            check("sb_mismatch", bus.mismatch, e.mis);
            check("sb_vec_cnt", bus.vec_cnt, e.vcnt);
            check("sb_fail_cnt", bus.fail_cnt, e.fcnt);
        end
    end

    task automatic quiet();
        bus.vec_valid = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input vec_t v, input bit counted);
        sb_t e;
        bus.vec_valid = 1'b1;
        {bus.a, bus.b, bus.c, bus.y1, bus.y2} = {v.a, v.b, v.c, v.y1, v.y2};
        if (counted) begin
            m_vcnt = (m_vcnt == 8'hFF) ? m_vcnt : m_vcnt + 8'd1;
            if (v.mis) m_fcnt = m_fcnt + 8'd1;
            e.due = cyc + 2;
            e.mis = v.mis;
            e.vcnt = m_vcnt;
            e.fcnt = m_fcnt;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.vec_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        m_vcnt = '0;
        m_fcnt = '0;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_pass"}, bus.pass, 0);
        check({tag, "_vec_cnt"}, bus.vec_cnt, 0);
        check({tag, "_fail_cnt"}, bus.fail_cnt, 0);
        check({tag, "_cov_map"}, bus.cov_map, 0);
        check({tag, "_first_fail"}, bus.first_fail, 0);
        check({tag, "_mismatch"}, bus.mismatch, 0);
    endtask

    initial begin
        tbl[0]  = mk(5'b000_00, 1'b0);
        tbl[1]  = mk(5'b001_01, 1'b0);
        tbl[2]  = mk(5'b010_01, 1'b0);
        tbl[3]  = mk(5'b011_10, 1'b0);
        tbl[4]  = mk(5'b100_01, 1'b0);
        tbl[5]  = mk(5'b101_10, 1'b0);
        tbl[6]  = mk(5'b110_10, 1'b0);
        tbl[7]  = mk(5'b111_11, 1'b0);
        tbl[8]  = mk(5'b110_00, 1'b1);
        tbl[9]  = mk(5'b111_00, 1'b1);
        tbl[10] = mk(5'b000_11, 1'b1);
        m_vcnt = '0;
        m_fcnt = '0;
        {bus.start, bus.stop, bus.vec_valid, bus.a, bus.b, bus.c, bus.y1, bus.y2} = '0;
        {bus2.start, bus2.stop, bus2.vec_valid, bus2.a, bus2.b, bus2.c, bus2.y1, bus2.y2} = '0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // All eight combinations, correct responses, back to back
        pulse_start();
        check("run_busy", bus.busy, 1);
        for (int i = 0; i < 8; i++) send(tbl[i], 1'b1);
        quiet();
        check("full_done_early", bus.done, 0);
        quiet();
        check("full_done", bus.done, 1);
        check("full_pass", bus.pass, 1);
        check("full_busy", bus.busy, 0);
        check("full_vec_cnt", bus.vec_cnt, 8);
        check("full_cov", bus.cov_map, 8'hFF);
        check("full_fail", bus.fail_cnt, 0);

        send(tbl[3], 1'b0);
        quiet();
        quiet();
        check("done_ignore_vec", bus.vec_cnt, 8);
        check("done_hold", bus.done, 1);

        // Two failures: first_fail latches the first one only
        pulse_start();
        send(tbl[8], 1'b1);
        send(tbl[9], 1'b1);
        quiet();
        quiet();
        check("fail_cnt2", bus.fail_cnt, 2);
        check("first_fail", bus.first_fail, 5'b110_00);
        check("fail_cov", bus.cov_map, 8'hC0);
        check("fail_no_done", bus.done, 0);
        send(tbl[10], 1'b1);
        quiet();
        quiet();
        check("fail_cnt3", bus.fail_cnt, 3);
        check("first_fail_kept", bus.first_fail, 5'b110_00);

        // Asynchronous reset mid-run
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        m_vcnt = '0;
        m_fcnt = '0;
        send(tbl[1], 1'b0);
        quiet();
        quiet();
        check("idle_ignore_vec", bus.vec_cnt, 0);
        check("idle_busy", bus.busy, 0);

        // Stop with the last vector still in stage 1
        pulse_start();
        for (int i = 0; i < 3; i++) send(tbl[i], 1'b1);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        quiet();
        check("stop_done", bus.done, 1);
        check("stop_pass", bus.pass, 0);
        check("stop_cov", bus.cov_map, 8'h07);
        check("stop_vec_cnt", bus.vec_cnt, 3);

        // Three consecutive strobes
        pulse_start();
        for (int i = 4; i < 7; i++) send(tbl[i], 1'b1);
        quiet();
        quiet();
        check("b2b_vec_cnt", bus.vec_cnt, 3);
        check("b2b_cov", bus.cov_map, 8'h70);

        // Start discards a vector sitting in stage 1
        send(tbl[0], 1'b0);
        pulse_start();
        quiet();
        quiet();
        check("restart_discard", bus.vec_cnt, 0);
        check("restart_cov", bus.cov_map, 0);

        // vec_valid in the start cycle is ignored
        bus.start = 1'b1;
        bus.vec_valid = 1'b1;
        {bus.a, bus.b, bus.c, bus.y1, bus.y2} = 5'b111_00;
        @(negedge clk);
        quiet();
        quiet();
        check("start_cycle_vec", bus.vec_cnt, 0);
        check("start_cycle_mismatch", bus.fail_cnt, 0);
        check("start_cycle_busy", bus.busy, 1);

        // Narrow counters saturate; start+stop together restarts
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus2.vec_valid = 1'b1;
            {bus2.a, bus2.b, bus2.c, bus2.y1, bus2.y2} = {tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].y1, tbl[i].y2};
            @(negedge clk);
        end
        bus2.vec_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("sat_vec_cnt", bus2.vec_cnt, 3);
        check("sat_cov", bus2.cov_map, 8'h3F);
        check("sat_fail", bus2.fail_cnt, 0);
        check("sat_busy", bus2.busy, 1);
        bus2.start = 1'b1;
        bus2.stop = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        bus2.stop = 1'b0;
        check("ss_busy", bus2.busy, 1);
        check("ss_done", bus2.done, 0);
        check("ss_vec_cnt", bus2.vec_cnt, 0);
        check("ss_cov", bus2.cov_map, 0);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
